// File: rtl/register_reader.sv
// register_reader: sends a register as a framed byte stream (header byte
// REG_ID, then the register snapshot MSB first) and then pulses read_ack.
// Requests that arrive while a frame is in flight are held in a one-deep
// pending flag and served once the block has returned to IDLE.
module register_reader #(
  parameter int         DATA_BYTES  = 4,
  parameter logic [7:0] REG_ID      = 8'h00,
  parameter bit         AUTO_REPORT = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    read_req,
  input  logic                    changed,
  input  logic [8*DATA_BYTES-1:0] data,
  input  logic                    tx_ready,
  output logic                    tx_valid,
  output logic [7:0]              tx_byte,
  output logic                    read_ack,
  output logic                    busy
);

  localparam int IDX_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_HEADER = 2'b01,
    ST_DATA   = 2'b10,
    ST_ACK    = 2'b11
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        w_next_idx;
  logic                    r_pending;
  logic                    w_next_pending;
  logic [8*DATA_BYTES-1:0] r_snap;
  logic [8*DATA_BYTES-1:0] w_next_snap;
  logic                    r_read_ack;
  logic                    r_busy;
  logic                    w_trigger;
  logic                    w_xfer;
  logic [IDX_W-1:0]        w_sel;
  logic [8*DATA_BYTES-1:0] w_shifted;

  // A pending request counts as a trigger so it is served on the first IDLE cycle.
  assign w_trigger = read_req | (AUTO_REPORT & changed) | r_pending;
  assign w_xfer    = tx_valid & tx_ready;

  // Byte index counts up, but the register goes out most significant byte first.
  assign w_sel     = LAST_IDX - r_idx;
  assign w_shifted = r_snap >> {w_sel, 3'b000};

  // State register plus registered read_ack/busy derived from the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_pending  <= 1'b0;
      r_snap     <= '0;
      r_read_ack <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_idx      <= w_next_idx;
      r_pending  <= w_next_pending;
      r_snap     <= w_next_snap;
      r_read_ack <= (w_next_state == ST_ACK);
      r_busy     <= (w_next_state != ST_IDLE);
    end
  end

  // Next-state, index, pending and snapshot logic.
  always_comb begin
    w_next_state   = r_state;
    w_next_idx     = r_idx;
    w_next_pending = r_pending;
    w_next_snap    = r_snap;
    case (r_state)
      ST_IDLE: begin
        if (w_trigger) begin
          w_next_state   = ST_HEADER;
          w_next_snap    = data;
          w_next_pending = 1'b0;
          w_next_idx     = '0;
        end else begin
          w_next_state   = ST_IDLE;
        end
      end
      ST_HEADER: begin
        w_next_pending = r_pending | read_req;
        if (w_xfer) begin
          w_next_state = ST_DATA;
          w_next_idx   = '0;
        end else begin
          w_next_state = ST_HEADER;
        end
      end
      ST_DATA: begin
        w_next_pending = r_pending | read_req;
        if (w_xfer) begin
          if (r_idx == LAST_IDX) begin
            w_next_state = ST_ACK;
            w_next_idx   = '0;
          end else begin
            w_next_idx   = r_idx + IDX_W'(1);
          end
        end else begin
          w_next_state = ST_DATA;
        end
      end
      ST_ACK: begin
        w_next_pending = r_pending | read_req;
        w_next_state   = ST_IDLE;
      end
      default: begin
        w_next_state   = ST_IDLE;
        w_next_idx     = '0;
        w_next_pending = 1'b0;
      end
    endcase
  end

  // Byte-stream outputs decoded from the registered state.
  always_comb begin
    tx_valid = 1'b0;
    tx_byte  = 8'h00;
    case (r_state)
      ST_HEADER: begin
        tx_valid = 1'b1;
        tx_byte  = REG_ID;
      end
      ST_DATA: begin
        tx_valid = 1'b1;
        tx_byte  = w_shifted[7:0];
      end
      default: begin
        tx_valid = 1'b0;
        tx_byte  = 8'h00;
      end
    endcase
  end

  assign read_ack = r_read_ack;
  assign busy     = r_busy;

endmodule
